// File: rtl/frame_sched_pkg.sv
// Shared types and default 800x480 raster timing for the denoise demo display scheduler.
package frame_sched_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_t;

    localparam logic [1:0] DISP_RAW  = 2'd0;
    localparam logic [1:0] DISP_BUF0 = 2'd1;
    localparam logic [1:0] DISP_BUF1 = 2'd2;

    localparam int H_W = 11;
    localparam int V_W = 10;

    localparam int DEF_H_ACTIVE     = 800;
    localparam int DEF_H_FP         = 210;
    localparam int DEF_H_SYNC       = 30;
    localparam int DEF_H_TOTAL      = 1056;
    localparam int DEF_V_ACTIVE     = 480;
    localparam int DEF_V_FP         = 22;
    localparam int DEF_V_SYNC       = 13;
    localparam int DEF_V_TOTAL      = 525;
    localparam int DEF_SYNC_ACT_LOW = 1;

endpackage

// File: rtl/raster_timing_gen.sv
// Raster counters plus registered sync/blank/pixel-position decode; everything freezes while en=0.
module raster_timing_gen
    import frame_sched_pkg::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_FP         = DEF_H_FP,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_FP         = DEF_V_FP,
    parameter int V_SYNC       = DEF_V_SYNC,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int SYNC_ACT_LOW = DEF_SYNC_ACT_LOW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    output logic [H_W-1:0] h_cnt,
    output logic [V_W-1:0] v_cnt,
    output logic           hsync,
    output logic           vsync,
    output logic           blank_n,
    output logic [H_W-1:0] pix_x,
    output logic [V_W-1:0] pix_y,
    output logic           frame_start
);

    localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
    localparam logic           SYNC_OFF = (SYNC_ACT_LOW != 0);

    logic active;
    logic hs_on;
    logic vs_on;

    always_comb begin
        active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_on  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs_on  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= SYNC_OFF;
            vsync       <= SYNC_OFF;
            blank_n     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            // frame_start stays a single-cycle pulse even when the raster stalls
            frame_start <= en && (h_cnt == '0) && (v_cnt == '0);
            if (en) begin
                h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + 1'b1;
                if (h_cnt == H_LAST)
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                hsync   <= hs_on ? ~SYNC_OFF : SYNC_OFF;
                vsync   <= vs_on ? ~SYNC_OFF : SYNC_OFF;
                blank_n <= active;
                pix_x   <= active ? h_cnt : '0;
                pix_y   <= active ? v_cnt : '0;
            end
        end
    end

endmodule

// File: rtl/frame_sched_ctrl.sv
// Display scheduler: raster timing plus ping-pong denoise launch/swap FSM, decided only at vertical blanking.
module frame_sched_ctrl
    import frame_sched_pkg::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_FP         = DEF_H_FP,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_FP         = DEF_V_FP,
    parameter int V_SYNC       = DEF_V_SYNC,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int SYNC_ACT_LOW = DEF_SYNC_ACT_LOW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           dn_enable,
    input  logic           show_denoised,
    input  logic           dn_done,
    output logic           dn_start,
    output logic           dn_dst_sel,
    output logic [1:0]     disp_sel,
    output logic           hsync,
    output logic           vsync,
    output logic           blank_n,
    output logic [H_W-1:0] pix_x,
    output logic [V_W-1:0] pix_y,
    output logic           frame_start,
    output logic [7:0]     overrun_cnt
);

    localparam logic [V_W-1:0] VB_LINE = V_W'(V_ACTIVE);

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           vb;

    sched_state_t state, state_nx;
    logic       front, front_nx;
    logic       back, back_nx;
    logic       disp_valid, valid_nx;
    logic       start_nx, dst_nx;
    logic [1:0] disp_nx;
    logic [7:0] ovr_nx;
    logic       swap, launch;

    raster_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_TOTAL(H_TOTAL),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_TOTAL(V_TOTAL),
        .SYNC_ACT_LOW(SYNC_ACT_LOW)
    ) u_raster (
        .clk(clk), .rst(rst), .en(en),
        .h_cnt(h_cnt), .v_cnt(v_cnt),
        .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
        .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start)
    );

    assign vb = en && (h_cnt == '0) && (v_cnt == VB_LINE);

    always_comb begin
        state_nx = state;
        front_nx = front;
        back_nx  = back;
        valid_nx = disp_valid;
        start_nx = 1'b0;
        dst_nx   = dn_dst_sel;
        disp_nx  = disp_sel;
        ovr_nx   = overrun_cnt;
        swap     = 1'b0;
        launch   = 1'b0;

        unique case (state)
            IDLE: if (vb && dn_enable) launch = 1'b1;
            RUN: begin
                if (dn_done && vb)
                    swap = 1'b1;
                else if (dn_done)
                    state_nx = DONE;
                else if (vb && overrun_cnt != 8'hFF)
                    ovr_nx = overrun_cnt + 8'd1;
            end
            DONE: if (vb) swap = 1'b1;
            default: state_nx = IDLE;
        endcase

        // A swap falls back to IDLE unless the relaunch below takes it straight to RUN
        if (swap) begin
            front_nx = back;
            back_nx  = ~back;
            valid_nx = 1'b1;
            state_nx = IDLE;
            if (dn_enable) launch = 1'b1;
        end
        if (launch) begin
            start_nx = 1'b1;
            dst_nx   = back_nx;
            state_nx = RUN;
        end
        if (vb)
            disp_nx = (show_denoised && valid_nx) ? (front_nx ? DISP_BUF1 : DISP_BUF0) : DISP_RAW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            front       <= 1'b0;
            back        <= 1'b0;
            disp_valid  <= 1'b0;
            dn_start    <= 1'b0;
            dn_dst_sel  <= 1'b0;
            disp_sel    <= DISP_RAW;
            overrun_cnt <= '0;
        end else begin
            state       <= state_nx;
            front       <= front_nx;
            back        <= back_nx;
            disp_valid  <= valid_nx;
            dn_start    <= start_nx;
            dn_dst_sel  <= dst_nx;
            disp_sel    <= disp_nx;
            overrun_cnt <= ovr_nx;
        end
    end

endmodule

// File: tb/tb_frame_sched_ctrl.sv
// Directed bench for frame_sched_ctrl using a shrunken raster so several frames fit in a short run.
module tb_frame_sched_ctrl;

    localparam int TH_ACTIVE = 16, TH_FP = 4, TH_SYNC = 3, TH_TOTAL = 28;
    localparam int TV_ACTIVE = 8, TV_FP = 2, TV_SYNC = 2, TV_TOTAL = 14;
    localparam int FRAME = TH_TOTAL * TV_TOTAL;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        bl;
        logic [10:0] px;
        logic [9:0]  py;
        logic        fs;
    } rast_t;

    localparam rast_t RST_EXP = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, px: '0, py: '0, fs: 1'b0};

    logic        clk = 1'b0;
    logic        rst, en, dn_enable, show_denoised, dn_done;
    logic        dn_start, dn_dst_sel, hsync, vsync, blank_n, frame_start;
    logic [1:0]  disp_sel;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [7:0]  overrun_cnt;

    rast_t rq[$];
    bit    lq[$];
    rast_t last_exp = RST_EXP;
    int    total = 0, bad = 0;
    int    mh = 0, mv = 0, cyc = 0;
    int    blank_hi = 0, hs_lo = 0, vs_lo = 0;
    int    fs_last = 0, fs_period = 0;
    bit    fs_seen = 1'b0;

    always #5 clk = ~clk;

    frame_sched_ctrl #(
        .H_ACTIVE(TH_ACTIVE), .H_FP(TH_FP), .H_SYNC(TH_SYNC), .H_TOTAL(TH_TOTAL),
        .V_ACTIVE(TV_ACTIVE), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_TOTAL(TV_TOTAL),
        .SYNC_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .dn_enable(dn_enable),
        .show_denoised(show_denoised), .dn_done(dn_done),
        .dn_start(dn_start), .dn_dst_sel(dn_dst_sel), .disp_sel(disp_sel),
        .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
        .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
        .overrun_cnt(overrun_cnt)
    );

    function automatic rast_t decode(input int h, input int v);
        rast_t r;
        logic  act;
        act  = (h < TH_ACTIVE) && (v < TV_ACTIVE);
        r.bl = act;
        r.hs = !((h >= TH_ACTIVE + TH_FP) && (h < TH_ACTIVE + TH_FP + TH_SYNC));
        r.vs = !((v >= TV_ACTIVE + TV_FP) && (v < TV_ACTIVE + TV_FP + TV_SYNC));
        r.px = act ? 11'(h) : 11'd0;
        r.py = act ? 10'(v) : 10'd0;
        r.fs = (h == 0) && (v == 0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: predict raster outputs, advance, then score raster and any launch against the queues.
    task automatic tick();
        rast_t e, g;
        bit    had, ed;
        if (rst) begin
            e = RST_EXP; mh = 0; mv = 0; fs_seen = 1'b0;
        end else if (en) begin
            e = decode(mh, mv);
            if (mh == TH_TOTAL - 1) begin
                mh = 0;
                mv = (mv == TV_TOTAL - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end else begin
            e = last_exp; e.fs = 1'b0;
        end
        rq.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = rq.pop_front();
        last_exp = e;
        g = {hsync, vsync, blank_n, pix_x, pix_y, frame_start};
        total++;
        assert (g === e) else begin
            bad++;
            $error("FAIL raster cyc=%0d got=%h expected=%h", cyc, g, e);
        end
        if (blank_n === 1'b1) blank_hi++;
        if (hsync === 1'b0) hs_lo++;
        if (vsync === 1'b0) vs_lo++;
        if (frame_start === 1'b1) begin
            if (fs_seen) fs_period = cyc - fs_last;
            fs_last = cyc;
            fs_seen = 1'b1;
        end
        if (dn_start !== 1'b0) begin
            had = (lq.size() > 0);
            ed  = had ? lq.pop_front() : 1'b0;
            total++;
            assert (had && dn_dst_sel === ed) else begin
                bad++;
                $error("FAIL launch cyc=%0d got dn_start=%b dst=%b expected pending=%0d dst=%b",
                       cyc, dn_start, dn_dst_sel, had, ed);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_done();
        dn_done = 1'b1; tick(); dn_done = 1'b0;
    endtask

    task automatic go_vb();
        int n = 0;
        while (!(mh == 0 && mv == TV_ACTIVE) && n < 2 * FRAME) begin
            tick(); n++;
        end
    endtask

    task automatic vb_edge();
        go_vb(); tick();
    endtask

    task automatic chk_sched(input string tag, input logic st, input logic dst,
                             input logic [1:0] ds, input logic [7:0] ovr);
        chk({tag, ".dn_start"}, 32'(dn_start), 32'(st));
        chk({tag, ".dn_dst_sel"}, 32'(dn_dst_sel), 32'(dst));
        chk({tag, ".disp_sel"}, 32'(disp_sel), 32'(ds));
        chk({tag, ".overrun_cnt"}, 32'(overrun_cnt), 32'(ovr));
    endtask

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, h0, v0;
        rst = 1'b1; en = 1'b0; dn_enable = 1'b0; show_denoised = 1'b0; dn_done = 1'b0;
        ticks(2);
        chk_sched("reset", 1'b0, 1'b0, 2'd0, 8'd0);
        rst = 1'b0;

        // Two bare frames of raster timing
        b0 = blank_hi; h0 = hs_lo; v0 = vs_lo;
        en = 1'b1;
        ticks(2 * FRAME);
        chk("blank_n_cycles", 32'(blank_hi - b0), 32'(2 * TH_ACTIVE * TV_ACTIVE));
        chk("hsync_low_cycles", 32'(hs_lo - h0), 32'(2 * TV_TOTAL * TH_SYNC));
        chk("vsync_low_cycles", 32'(vs_lo - v0), 32'(2 * TV_SYNC * TH_TOTAL));
        chk("frame_start_period", 32'(fs_period), 32'(FRAME));
        chk_sched("idle_no_launch", 1'b0, 1'b0, 2'd0, 8'd0);

        // Normal ping-pong
        dn_enable = 1'b1; show_denoised = 1'b1;
        lq.push_back(1'b0);
        vb_edge();
        chk_sched("launch0", 1'b1, 1'b0, 2'd0, 8'd0);
        tick();
        chk("launch0_pulse", 32'(dn_start), 32'd0);
        ticks(100); pulse_done();
        lq.push_back(1'b1);
        vb_edge();
        chk_sched("swap_buf0", 1'b1, 1'b1, 2'd1, 8'd0);
        ticks(100); pulse_done();
        lq.push_back(1'b0);
        vb_edge();
        chk_sched("swap_buf1", 1'b1, 1'b0, 2'd2, 8'd0);

        // Late engine: two missed boundaries
        vb_edge();
        chk_sched("overrun1", 1'b0, 1'b0, 2'd2, 8'd1);
        vb_edge();
        chk_sched("overrun2", 1'b0, 1'b0, 2'd2, 8'd2);
        ticks(30); pulse_done();
        lq.push_back(1'b1);
        vb_edge();
        chk_sched("late_swap", 1'b1, 1'b1, 2'd1, 8'd2);

        // dn_done exactly on the boundary cycle
        go_vb();
        dn_done = 1'b1;
        lq.push_back(1'b0);
        tick();
        dn_done = 1'b0;
        chk_sched("done_on_vb", 1'b1, 1'b0, 2'd2, 8'd2);

        // show_denoised changes mid-frame take effect only at vb
        ticks(100); pulse_done();
        for (int n = 0; mv != 3 && n < FRAME; n++) tick();
        show_denoised = 1'b0;
        ticks(5);
        chk("show_off_midframe", 32'(disp_sel), 32'd2);
        lq.push_back(1'b1);
        vb_edge();
        chk_sched("show_off_vb", 1'b1, 1'b1, 2'd0, 8'd2);
        show_denoised = 1'b1;
        ticks(5);
        chk("show_on_midframe", 32'(disp_sel), 32'd0);
        ticks(100); pulse_done();
        lq.push_back(1'b0);
        vb_edge();
        chk_sched("show_on_vb", 1'b1, 1'b0, 2'd2, 8'd2);

        // dn_enable dropped mid-RUN: finish, swap, then idle
        dn_enable = 1'b0;
        ticks(100); pulse_done();
        vb_edge();
        chk_sched("disable_swap", 1'b0, 1'b0, 2'd1, 8'd2);
        vb_edge();
        chk_sched("disable_idle", 1'b0, 1'b0, 2'd1, 8'd2);

        // Reset during RUN; stale dn_done afterwards must be ignored
        dn_enable = 1'b1;
        lq.push_back(1'b1);
        vb_edge();
        chk_sched("pre_reset_launch", 1'b1, 1'b1, 2'd1, 8'd2);
        ticks(50);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_sched("mid_reset", 1'b0, 1'b0, 2'd0, 8'd0);
        chk("mid_reset.blank_n", 32'(blank_n), 32'd0);
        chk("mid_reset.hsync", 32'(hsync), 32'd1);
        ticks(10); pulse_done();
        ticks(5);
        chk_sched("stale_done", 1'b0, 1'b0, 2'd0, 8'd0);
        lq.push_back(1'b0);
        vb_edge();
        chk_sched("post_reset_launch", 1'b1, 1'b0, 2'd0, 8'd0);

        // en=0 freezes the boundary but dn_done is still captured
        ticks(20);
        en = 1'b0;
        ticks(3); pulse_done(); ticks(3);
        en = 1'b1;
        go_vb();
        en = 1'b0;
        ticks(5);
        chk_sched("frozen_vb", 1'b0, 1'b0, 2'd0, 8'd0);
        en = 1'b1;
        lq.push_back(1'b1);
        tick();
        chk_sched("thawed_vb", 1'b1, 1'b1, 2'd1, 8'd0);

        ticks(3);
        chk("launch_queue_drained", 32'(lq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
